// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream loader for the instruction memory write port
// Packs little-endian byte pairs into halfwords and holds the core in reset while loading.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned MAX_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [15:0] din,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_DATA_LO = 3'd3,
        S_DATA_HI = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [16:0] MAX_HW = 17'(2 * MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_len;
    logic [7:0]  r_lo;
    logic [16:0] r_idx;
    logic        r_err;
    logic [31:0] r_waddr;
    logic [15:0] r_din;

    logic        w_xfer;
    logic [15:0] w_len_full;
    logic [16:0] w_idx_inc;

    assign w_xfer     = in_valid && in_ready;
    assign w_len_full = {in_data, r_len[7:0]};
    assign w_idx_inc  = r_idx + 17'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_LEN_LO;
            S_LEN_LO:       if (w_xfer) w_next = S_LEN_HI;
            S_LEN_HI:       if (w_xfer) w_next = (w_len_full == 16'd0) ? S_DONE : S_DATA_LO;
            S_DATA_LO:      if (w_xfer) w_next = S_DATA_HI;
            S_DATA_HI:      if (w_xfer) w_next = S_WRITE;
            // index counts halfwords, so the load ends at twice the word count
            S_WRITE:        w_next = (w_idx_inc == {r_len, 1'b0}) ? S_DONE : S_DATA_LO;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_hold = 1'b0;
        we       = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            S_WRITE: begin
                cpu_hold = 1'b1;
                we       = (r_idx < MAX_HW);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len   <= 16'd0;
            r_lo    <= 8'd0;
            r_idx   <= 17'd0;
            r_err   <= 1'b0;
            r_waddr <= 32'd0;
            r_din   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        r_idx <= 17'd0;
                    end
                end
                S_LEN_LO: if (w_xfer) r_len[7:0] <= in_data;
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= in_data;
                        if (w_len_full != 16'd0) r_err <= ({16'd0, w_len_full} > MAX_WORDS);
                    end
                end
                S_DATA_LO: if (w_xfer) r_lo <= in_data;
                S_DATA_HI: begin
                    if (w_xfer) begin
                        r_din   <= {in_data, r_lo};
                        r_waddr <= BASE_ADDR + {14'd0, r_idx, 1'b0};
                    end
                end
                S_WRITE: r_idx <= w_idx_inc;
                default: ;
            endcase
        end
    end

    assign err   = r_err;
    assign waddr = r_waddr;
    assign din   = r_din;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle processor's instruction memory: the writer end of the instruction-memory write port (`we`, `waddr`, `din`) that the core's fetch path reads through `komut`. It accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes into 16-bit halfwords, and writes them into memory at consecutive byte addresses. While loading it holds the core in reset, then releases it and flags completion.

## Interface

Parameters:
- `BASE_ADDR`, 32'd0: byte address of the first instruction written.
- `MAX_WORDS`, 32: instruction-memory capacity in 32-bit words.

Ports:
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-low; low forces every register to its reset value immediately.
- `start`  in  1: begin a load; sampled in IDLE and DONE only.
- `in_valid`  in  1: `in_data` holds a byte.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `we`  out  1: memory write enable, one-cycle pulse per halfword.
- `waddr`  out  32: memory byte address of the halfword.
- `din`  out  16: halfword to write.
- `cpu_hold`  out  1: high while loading; drives the core's reset hold.
- `done`  out  1: load finished; held until next `start`.
- `err`  out  1: word count exceeded `MAX_WORDS`; held until next `start`.

## Operation

- Stream format, little-endian throughout:
  - 2 bytes: word count N.
  - 4N bytes: instruction words, least significant byte first.
- Handshake: a byte transfers on a rising edge with `in_valid && in_ready`. `in_ready` is high only in LEN_LO, LEN_HI, DATA_LO and DATA_HI. `in_data` is ignored otherwise.
- States and transitions:
  - IDLE: `start` → LEN_LO; clears `done` and `err`; halfword index ← 0.
  - LEN_LO: transfer → N[7:0] latched → LEN_HI.
  - LEN_HI: transfer → N[15:8] latched. If N == 0 → DONE. Otherwise → DATA_LO; `err` ← 1 if N > MAX_WORDS.
  - DATA_LO: transfer → low byte latched → DATA_HI.
  - DATA_HI: transfer → halfword {byte, low} registered → WRITE.
  - WRITE (one cycle):
    - `we` = 1 iff halfword index < 2·MAX_WORDS; otherwise the write is suppressed but the bytes were still consumed.
    - `waddr` = BASE_ADDR + 2·index; `din` = halfword.
    - Index increments. If the new index == 2N → DONE; otherwise → DATA_LO.
  - DONE: `done` = 1; `start` → LEN_LO (re-load, same clearing as IDLE).
- Arithmetic:
  - Halfword index is 17 bits; 2N is computed in 17 bits, with no overflow for N up to 65535.
  - `waddr` arithmetic is modulo 2^32.
- `cpu_hold` = 1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI and WRITE; 0 in IDLE and DONE.
- `start` asserted in any loading state is ignored.
- A stalled `in_valid` simply holds the state; there is no timeout.

## Timing

- Reset values: state IDLE; `in_ready`, `we`, `cpu_hold`, `done`, `err` all 0; `waddr` = 0; `din` = 0; N = 0; index = 0.
- All outputs are registered or decoded from the state register; none combinationally depends on `in_valid`.
- Latency per halfword: 2 transfer cycles + 1 WRITE cycle, so 6 cycles minimum per instruction word at full input rate.
- `we` pulses occur on the WRITE cycle. `waddr`/`din` are stable for that cycle and hold their last values afterwards.
- `done` and `cpu_hold` change on the same edge that leaves the last WRITE (or LEN_HI when N == 0).
- Reset asserted mid-load: immediate IDLE, `we` drops without completing the write, `cpu_hold` drops. Partially written memory contents are left as-is.

## Test plan

- Load N = 2, bytes 02 00 | 13 00 50 00 | 93 00 A0 00:
  - Writes (waddr, din) = (0, 0x0013), (2, 0x0050), (4, 0x0093), (6, 0x00A0).
  - `done` = 1; `cpu_hold` = 0; `err` = 0; exactly 4 `we` pulses.
- N = 0 (bytes 00 00): DONE two transfers after `start`, no `we` pulse, `done` = 1.
- Random `in_valid` gaps on the N = 2 stream: the same four writes in the same order; no write while `in_valid` is low mid-halfword.
- N = 33 with MAX_WORDS = 32:
  - `err` = 1 after LEN_HI; 64 writes, the last at waddr 126.
  - The final 4 bytes are consumed, not written; `done` = 1.
- `reset` low during DATA_HI of the second word: outputs return to reset values that cycle. Then `start` with a fresh N = 1 stream writes at waddr 0 and 2.
- `start` pulsed during DATA_LO is ignored. After DONE, a new `start` clears `done`, raises `cpu_hold`, and restarts from waddr BASE_ADDR.
